// File: rtl/dac_pkg.sv
// Shared definitions for the alarm controller: FSM encoding, BCD time constants,
// default timing parameters and BCD<->binary helpers for two-digit fields.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } alarm_state_e;

  localparam logic [15:0] BCD_MIDNIGHT = 16'h0000;
  localparam logic [15:0] BCD_LAST     = 16'h2359;

  localparam int DEF_RING_MINUTES   = 5;
  localparam int DEF_SNOOZE_MINUTES = 9;

  function automatic logic [6:0] bcd2_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller (slave) and its driver (master).
// All inputs are sampled on posedge clk; outputs are decoded from registered state.
interface alarm_controller_if;
  logic        load_alarm;
  logic [15:0] set_data;
  logic [15:0] time_data;
  logic        one_minute;
  logic        alarm_on;
  logic        stop_alarm;
  logic        snooze;
  logic [15:0] alarm_data;
  logic        alarm_sound;
  logic        snooze_active;
  logic [1:0]  state_dbg;
  logic [15:0] snooze_time_dbg;

  modport master (
    output load_alarm, set_data, time_data, one_minute, alarm_on, stop_alarm, snooze,
    input  alarm_data, alarm_sound, snooze_active, state_dbg, snooze_time_dbg
  );

  modport slave (
    input  load_alarm, set_data, time_data, one_minute, alarm_on, stop_alarm, snooze,
    output alarm_data, alarm_sound, snooze_active, state_dbg, snooze_time_dbg
  );
endinterface

// File: rtl/bcd_time_add.sv
// Combinational BCD HH:MM plus a binary minute count (0..59), carrying minutes
// into hours and wrapping 23:59 -> 00:00.
module bcd_time_add
  import dac_pkg::*;
(
  input  logic [15:0] time_i,
  input  logic [5:0]  add_min_i,
  output logic [15:0] sum_o
);

  logic [6:0] min_bin;
  logic [6:0] hr_bin;
  logic [6:0] min_sum;
  logic [6:0] hr_sum;

  always_comb begin
    min_bin = bcd2_to_bin(time_i[7:0]);
    hr_bin  = bcd2_to_bin(time_i[15:8]);
    min_sum = min_bin + 7'(add_min_i);
    hr_sum  = hr_bin;
    if (min_sum >= 7'd60) begin
      min_sum = min_sum - 7'd60;
      hr_sum  = hr_bin + 7'd1;
    end
    if (hr_sum >= 7'd24) begin
      hr_sum = hr_sum - 7'd24;
    end
    sum_o = {bin_to_bcd2(hr_sum), bin_to_bcd2(min_sum)};
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: IDLE / RINGING / SNOOZE FSM with edge-qualified time match.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_controller
  import dac_pkg::*;
#(
  parameter int RING_MINUTES   = DEF_RING_MINUTES,
  parameter int SNOOZE_MINUTES = DEF_SNOOZE_MINUTES
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  localparam logic [3:0] RING_LIMIT = 4'(RING_MINUTES);
  localparam logic [5:0] SNOOZE_ADD = 6'(SNOOZE_MINUTES);

  alarm_state_e state_q, state_d;
  logic [15:0]  alarm_data_q, alarm_data_d;
  logic [3:0]   ring_cnt_q, ring_cnt_d;
  logic         match_q, match_d;
  logic [15:0]  target;
  logic         match;
  logic         trigger;

`ifdef ALARM_SNOOZE_EN
  logic [15:0] snooze_time_q, snooze_time_d;
  logic [15:0] snooze_sum;

  bcd_time_add u_snooze_add (
    .time_i    (bus.time_data),
    .add_min_i (SNOOZE_ADD),
    .sum_o     (snooze_sum)
  );

  assign target              = (state_q == ST_SNOOZE) ? snooze_time_q : alarm_data_q;
  assign bus.snooze_active   = (state_q == ST_SNOOZE);
  assign bus.snooze_time_dbg = snooze_time_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) snooze_time_q <= BCD_MIDNIGHT;
    else        snooze_time_q <= snooze_time_d;
  end
`else
  logic [6:0] unused_snooze_cfg;
  assign unused_snooze_cfg   = {bus.snooze, SNOOZE_ADD};
  assign target              = alarm_data_q;
  assign bus.snooze_active   = 1'b0;
  assign bus.snooze_time_dbg = BCD_MIDNIGHT;
`endif

  // Ring only on the first cycle of a match so a held time cannot retrigger.
  assign match   = (bus.time_data == target);
  assign trigger = bus.alarm_on & match & ~match_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      alarm_data_q <= BCD_MIDNIGHT;
      ring_cnt_q   <= 4'd0;
      match_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      alarm_data_q <= alarm_data_d;
      ring_cnt_q   <= ring_cnt_d;
      match_q      <= match_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alarm_data_d = alarm_data_q;
    ring_cnt_d   = ring_cnt_q;
    match_d      = match;
`ifdef ALARM_SNOOZE_EN
    snooze_time_d = snooze_time_q;
`endif
    if (bus.load_alarm) begin
      alarm_data_d = bus.set_data;
      state_d      = ST_IDLE;
    end else if (!bus.alarm_on || bus.stop_alarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d    = ST_RINGING;
            ring_cnt_d = 4'd0;
          end
        end
        ST_RINGING: begin
`ifdef ALARM_SNOOZE_EN
          if (bus.snooze) begin
            state_d       = ST_SNOOZE;
            snooze_time_d = snooze_sum;
          end else
`endif
          if (bus.one_minute) begin
            if (ring_cnt_q + 4'd1 == RING_LIMIT) state_d = ST_IDLE;
            else                                 ring_cnt_d = ring_cnt_q + 4'd1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (trigger) begin
            state_d    = ST_RINGING;
            ring_cnt_d = 4'd0;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.alarm_data  = alarm_data_q;
  assign bus.alarm_sound = (state_q == ST_RINGING);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: vector table for single-cycle behaviour,
// hand sequences for timeout, snooze, async reset and the BCD adder.
module tb_alarm_controller;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  alarm_controller_if bus();

  alarm_controller #(.RING_MINUTES(5), .SNOOZE_MINUTES(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] add_tm;
  logic [5:0]  add_min;
  logic [15:0] add_sum;

  bcd_time_add u_add (
    .time_i    (add_tm),
    .add_min_i (add_min),
    .sum_o     (add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] set;
    logic [15:0] tm;
    logic        on;
    logic        stop;
    logic        snz;
    logic        exp_sound;
    logic [15:0] exp_ad;
  } vec_t;

  typedef struct {
    logic [15:0] tm;
    logic [5:0]  add;
    logic [15:0] exp_sum;
  } add_vec_t;

  vec_t     vecs[24];
  add_vec_t avecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic load, input logic [15:0] set, input logic [15:0] tm,
                       input logic on, input logic stop, input logic snz);
    bus.load_alarm = load;
    bus.set_data   = set;
    bus.time_data  = tm;
    bus.alarm_on   = on;
    bus.stop_alarm = stop;
    bus.snooze     = snz;
  endtask

  task automatic start_ring(input logic [15:0] t_alarm, input logic [15:0] t_before);
    drive(1'b1, t_alarm, t_before, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0000, t_before, 1'b1, 1'b0, 1'b0);
    step();
    bus.time_data = t_alarm;
    step();
    check("ring_start", 16'(bus.alarm_sound), 16'h1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0730, 16'h0729, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0729, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0730};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0730};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0730};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0731, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0729, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0730};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[10] = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[11] = '{1'b0, 16'h0000, 16'h0729, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[12] = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0730};
    vecs[13] = '{1'b1, 16'h1234, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234};
    vecs[14] = '{1'b1, 16'h0A7F, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0A7F};
    vecs[15] = '{1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0A7F};
    vecs[16] = '{1'b1, 16'h0730, 16'h0729, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[17] = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0730};
    vecs[18] = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0730};
    vecs[19] = '{1'b0, 16'h0000, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[20] = '{1'b0, 16'h0000, 16'h0800, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[21] = '{1'b0, 16'h0000, 16'h0729, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[22] = '{1'b0, 16'h0000, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0730};
    vecs[23] = '{1'b0, 16'h0000, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0730};

    avecs[0] = '{16'h2355, 6'd9,  16'h0004};
    avecs[1] = '{16'h0729, 6'd9,  16'h0738};
    avecs[2] = '{16'h0755, 6'd9,  16'h0804};
    avecs[3] = '{16'h0959, 6'd1,  16'h1000};
    avecs[4] = '{16'h1950, 6'd15, 16'h2005};
    avecs[5] = '{16'h2359, 6'd1,  16'h0000};
    avecs[6] = '{16'h1200, 6'd59, 16'h1259};
    avecs[7] = '{16'h0001, 6'd59, 16'h0100};
    avecs[8] = '{16'h2300, 6'd59, 16'h2359};

    reset          = 1'b1;
    bus.one_minute = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    add_tm  = 16'h0000;
    add_min = 6'd0;
    #1 reset = 1'b0;
    #2;
    check("rst_sound", 16'(bus.alarm_sound), 16'h0);
    check("rst_snooze_active", 16'(bus.snooze_active), 16'h0);
    check("rst_alarm_data", bus.alarm_data, 16'h0000);
    check("rst_state", 16'(bus.state_dbg), 16'h0);
    check("rst_snooze_time", bus.snooze_time_dbg, 16'h0000);
    @(negedge clk);
    bus.alarm_on = 1'b1;
    reset = 1'b1;
    step();
    check("post_rst_no_ring", 16'(bus.alarm_sound), 16'h0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].load, vecs[i].set, vecs[i].tm, vecs[i].on, vecs[i].stop, vecs[i].snz);
      step();
      check($sformatf("row%0d_sound", i), 16'(bus.alarm_sound), 16'(vecs[i].exp_sound));
      check($sformatf("row%0d_snooze_active", i), 16'(bus.snooze_active), 16'h0);
      check($sformatf("row%0d_alarm_data", i), bus.alarm_data, vecs[i].exp_ad);
    end

    // Automatic stop after five minute ticks while ringing.
    start_ring(16'h0730, 16'h0729);
    for (int i = 1; i <= 5; i++) begin
      bus.time_data  = 16'h0730 + 16'(i);
      bus.one_minute = 1'b1;
      step();
      bus.one_minute = 1'b0;
      check($sformatf("timeout_tick%0d", i), 16'(bus.alarm_sound), (i < 5) ? 16'h1 : 16'h0);
      step();
      check($sformatf("timeout_gap%0d", i), 16'(bus.alarm_sound), (i < 5) ? 16'h1 : 16'h0);
    end

`ifdef ALARM_SNOOZE_EN
    start_ring(16'h2355, 16'h2354);
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
    check("snz_active", 16'(bus.snooze_active), 16'h1);
    check("snz_sound", 16'(bus.alarm_sound), 16'h0);
    check("snz_state", 16'(bus.state_dbg), 16'h2);
    check("snz_time", bus.snooze_time_dbg, 16'h0004);
    bus.time_data = 16'h0000;
    step();
    check("snz_wait0", 16'(bus.snooze_active), 16'h1);
    bus.time_data = 16'h0003;
    step();
    check("snz_wait3", 16'(bus.snooze_active), 16'h1);
    bus.time_data = 16'h0004;
    step();
    check("snz_rering_sound", 16'(bus.alarm_sound), 16'h1);
    check("snz_rering_active", 16'(bus.snooze_active), 16'h0);
    bus.stop_alarm = 1'b1;
    step();
    bus.stop_alarm = 1'b0;
    check("snz_stop", 16'(bus.alarm_sound), 16'h0);
`else
    start_ring(16'h0730, 16'h0729);
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
    check("nosnz_sound", 16'(bus.alarm_sound), 16'h1);
    check("nosnz_active", 16'(bus.snooze_active), 16'h0);
    check("nosnz_state", 16'(bus.state_dbg), 16'h1);
    bus.stop_alarm = 1'b1;
    step();
    bus.stop_alarm = 1'b0;
    check("nosnz_stop", 16'(bus.alarm_sound), 16'h0);
`endif

    // Asynchronous reset in the middle of ringing, then release at 00:00.
    start_ring(16'h0730, 16'h0729);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sound", 16'(bus.alarm_sound), 16'h0);
    check("async_rst_alarm_data", bus.alarm_data, 16'h0000);
    check("async_rst_state", 16'(bus.state_dbg), 16'h0);
    bus.time_data = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_midnight%0d", i), 16'(bus.alarm_sound), 16'h0);
    end

    for (int i = 0; i < 9; i++) begin
      add_tm  = avecs[i].tm;
      add_min = avecs[i].add;
      #1;
      check($sformatf("bcd_add%0d", i), add_sum, avecs[i].exp_sum);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
